// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: WIDTH-bit add streamed through one 4-bit carry-lookahead cell, LSB nibble first
// Ports: clk/rst (async, active-high); in_valid/in_ready + a, b, c_in operand handshake;
//        out_valid/out_ready + sum, c_out result handshake.
// Optional NSA_SUB_EN macro adds sub (subtract request) and ovf (signed overflow).
module nibble_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
`ifdef NSA_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
`ifdef NSA_SUB_EN
    ,
    output logic             ovf
`endif
);
    localparam int NIB = WIDTH / 4;
    localparam int IW = $clog2(NIB);
    localparam logic [IW-1:0] LAST = IW'(NIB - 1);

    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

    state_t state, state_n;
    logic [WIDTH-1:0] a_q, b_q, sum_q, b_eff;
    logic [IW-1:0] idx;
    logic carry, c_init, c_out_q;
    logic [3:0] cla_a, cla_b, g, p, cla_s;
    logic [4:0] c;

`ifdef NSA_SUB_EN
    logic ovf_q;
    assign b_eff = sub ? ~b : b;
    assign c_init = sub | c_in;
    assign ovf = ovf_q;
`else
    assign b_eff = b;
    assign c_init = c_in;
`endif

    // 4-bit carry-lookahead cell; the only combinational path between registers
    assign cla_a = a_q[4*idx+:4];
    assign cla_b = b_q[4*idx+:4];
    assign g = cla_a & cla_b;
    assign p = cla_a ^ cla_b;
    assign c[0] = carry;
    assign c[1] = g[0] | (p[0] & c[0]);
    assign c[2] = g[1] | (p[1] & g[0]) | ((&p[1:0]) & c[0]);
    assign c[3] = g[2] | (p[2] & g[1]) | ((&p[2:1]) & g[0]) | ((&p[2:0]) & c[0]);
    assign c[4] = g[3] | (p[3] & g[2]) | ((&p[3:2]) & g[1]) | ((&p[3:1]) & g[0]) | ((&p[3:0]) & c[0]);
    assign cla_s = p ^ c[3:0];

    assign in_ready = (state == IDLE);
    assign out_valid = (state == DONE);
    assign sum = sum_q;
    assign c_out = c_out_q;

    always_comb begin
        state_n = state;
        case (state)
            IDLE: state_n = in_valid ? ADD : IDLE;
            ADD: state_n = (idx == LAST) ? DONE : ADD;
            default: state_n = out_ready ? IDLE : DONE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else state <= state_n;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q <= '0;
            b_q <= '0;
            carry <= 1'b0;
            idx <= '0;
            sum_q <= '0;
            c_out_q <= 1'b0;
`ifdef NSA_SUB_EN
            ovf_q <= 1'b0;
`endif
        end else if (state == IDLE && in_valid) begin
            a_q <= a;
            b_q <= b_eff;
            carry <= c_init;
            idx <= '0;
        end else if (state == ADD) begin
            sum_q[4*idx+:4] <= cla_s;
            carry <= c[4];
            idx <= idx + 1'b1;
            if (idx == LAST) begin
                c_out_q <= c[4];
`ifdef NSA_SUB_EN
                ovf_q <= (a_q[WIDTH-1] == b_q[WIDTH-1]) && (cla_s[3] != a_q[WIDTH-1]);
`endif
            end
        end
    end
endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb_nibble_serial_adder: vector table, corner sequences and random ops against an arithmetic model
module tb_nibble_serial_adder;
    localparam int W = 16;
    localparam int NIB = W / 4;

    logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, c_in = 1'b0, sub = 1'b0, out_ready = 1'b1;
    logic [W-1:0] a = '0, b = '0, sum;
    logic in_ready, out_valid, c_out;
`ifdef NSA_SUB_EN
    logic ovf;
`endif
    int passed = 0, total = 0;

    nibble_serial_adder #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .c_in(c_in),
`ifdef NSA_SUB_EN
        .sub(sub), .ovf(ovf),
`endif
        .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .c_out(c_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a, b;
        logic ci, sb;
        logic [W-1:0] es;
        logic ec, eo;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // {ovf, c_out, sum} from plain integer arithmetic
    function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci, input logic sb);
        logic [W-1:0] be;
        logic [W:0] r;
        int s;
        logic cinit;
        be = sb ? ~y : y;
        cinit = sb ? 1'b1 : ci;
        r = {1'b0, x} + {1'b0, be} + {{W{1'b0}}, cinit};
        s = int'($signed(x)) + int'($signed(be)) + int'(cinit);
        return {(s > 32767 || s < -32768), r};
    endfunction

    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic ci, input logic sb,
                          input int hold, output logic [W-1:0] rs, output logic rc, output logic ro, output int lat);
        bit seen;
        @(negedge clk);
        a = ta; b = tb_; c_in = ci; sub = sb; in_valid = 1'b1;
        chk("in_ready_idle", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0; a = W'($urandom); b = W'($urandom); c_in = 1'($urandom); sub = 1'($urandom);
        lat = 0;
        seen = 0;
        for (int k = 1; k <= 20 && !seen; k++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                seen = 1;
                lat = k;
            end
        end
        if (!seen) chk("out_valid_timeout", out_valid, 1);
        rs = sum;
        rc = c_out;
`ifdef NSA_SUB_EN
        ro = ovf;
`else
        ro = 1'b0;
`endif
        if (hold > 0) out_ready = 1'b0;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            in_valid = 1'($urandom); a = W'($urandom); b = W'($urandom); c_in = 1'($urandom);
            @(posedge clk);
            #1;
            chk("hold_sum", sum, rs);
            chk("hold_cout", c_out, rc);
            chk("hold_in_ready", in_ready, 0);
            chk("hold_out_valid", out_valid, 1);
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("out_valid_drop", out_valid, 0);
        chk("in_ready_after", in_ready, 1);
    endtask

    task automatic check_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                            input logic ci, input logic sb, input int hold,
                            input logic [W-1:0] es, input logic ec, input logic eo);
        logic [W-1:0] rs;
        logic rc, ro;
        int lat;
        run_op(ta, tb_, ci, sb, hold, rs, rc, ro, lat);
        chk({tag, "_latency"}, lat, NIB);
        chk({tag, "_sum"}, rs, es);
        chk({tag, "_cout"}, rc, ec);
`ifdef NSA_SUB_EN
        chk({tag, "_ovf"}, ro, eo);
`else
        if (eo === 1'bx) chk({tag, "_ovf_x"}, ro, 0);
`endif
    endtask

    initial begin
        vec_t v[$];
        logic [W+1:0] m;
        bit seen;
        logic [W-1:0] ra, rb;
        logic rci, rsb;
        v.push_back('{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0});
        v.push_back('{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0});
        v.push_back('{16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0});
        v.push_back('{16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0});
        v.push_back('{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1});
        v.push_back('{16'hA5A5, 16'h5A5A, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0});
`ifdef NSA_SUB_EN
        v.push_back('{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0});
        v.push_back('{16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1});
`endif
        #2;
        chk("rst_sum", sum, 0);
        chk("rst_cout", c_out, 0);
        chk("rst_out_valid", out_valid, 0);
`ifdef NSA_SUB_EN
        chk("rst_ovf", ovf, 0);
`endif
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("in_ready_post_rst", in_ready, 1);

        foreach (v[i]) check_op($sformatf("vec%0d", i), v[i].a, v[i].b, v[i].ci, v[i].sb, 0, v[i].es, v[i].ec, v[i].eo);

        check_op("hold", 16'h0F0F, 16'h0101, 1'b1, 1'b0, 10, 16'h1011, 1'b0, 1'b0);

        @(negedge clk);
        a = 16'h00FF; b = 16'h0001; c_in = 1'b0; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst_sum", sum, 0);
        chk("midrst_cout", c_out, 0);
        chk("midrst_out_valid", out_valid, 0);
`ifdef NSA_SUB_EN
        chk("midrst_ovf", ovf, 0);
`endif
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1;
        end
        chk("midrst_no_valid", seen, 0);
        chk("midrst_in_ready", in_ready, 1);
        check_op("after_rst", 16'h0001, 16'h0001, 1'b0, 1'b0, 0, 16'h0002, 1'b0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rci = 1'($urandom);
`ifdef NSA_SUB_EN
            rsb = 1'($urandom);
`else
            rsb = 1'b0;
`endif
            m = model(ra, rb, rci, rsb);
            check_op($sformatf("rnd%0d", i), ra, rb, rci, rsb, (i % 7 == 3) ? 2 : 0, m[W-1:0], m[W], m[W+1]);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
